stream_switch_nxm: RTL

Packet-aware N×M AXI4-Stream crossbar for the 250 MHz user box; routes each packet from any QDMA/adapter source to any destination, selected by the 16-bit `tuser_dst` field of the first beat. It generalises the fixed 2-interface shorted switch to arbitrary source and destination counts. It adds per-destination round-robin arbitration with packet-granular locking, source-index stamping, and counted drop of unroutable packets.

---
 rtl/stream_switch_nxm.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/stream_switch_nxm.sv
// Packet-aware NxM AXI4-Stream crossbar: per-destination round-robin arbitration with
// packet-granular locking, optional source-index stamping and counted drop of bad routes.
module stream_switch_nxm #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned NUM_DST   = 4,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned STAMP_SRC = 1
) (
    input  logic                          axis_aclk,
    input  logic                          mod_rstn,
    output logic                          mod_rst_done,

    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [DATA_W*NUM_SRC-1:0]     s_axis_tdata,
    input  logic [DATA_W/8*NUM_SRC-1:0]   s_axis_tkeep,
    input  logic [16*NUM_SRC-1:0]         s_axis_tuser_size,
    input  logic [16*NUM_SRC-1:0]         s_axis_tuser_src,
    input  logic [16*NUM_SRC-1:0]         s_axis_tuser_dst,

    output logic [NUM_DST-1:0]            m_axis_tvalid,
    output logic [NUM_DST-1:0]            m_axis_tlast,
    input  logic [NUM_DST-1:0]            m_axis_tready,
    output logic [DATA_W*NUM_DST-1:0]     m_axis_tdata,
    output logic [DATA_W/8*NUM_DST-1:0]   m_axis_tkeep,
    output logic [16*NUM_DST-1:0]         m_axis_tuser_size,
    output logic [16*NUM_DST-1:0]         m_axis_tuser_src,
    output logic [16*NUM_DST-1:0]         m_axis_tuser_dst,

    output logic [31:0]                   drop_count
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Granted sources are tracked by the destination holding them; SrcDrop marks a
    // source discarding the remainder of an unroutable packet.
    typedef enum logic {SrcHead, SrcDrop} src_state_e;
    typedef enum logic {DstIdle, DstBusy} dst_state_e;

    src_state_e        src_state_q [NUM_SRC];
    src_state_e        src_state_d [NUM_SRC];
    dst_state_e        dst_state_q [NUM_DST];
    dst_state_e        dst_state_d [NUM_DST];
    logic [SW-1:0]     grant_q     [NUM_DST];
    logic [SW-1:0]     grant_d     [NUM_DST];
    logic [SW-1:0]     rr_ptr_q    [NUM_DST];
    logic [SW-1:0]     rr_ptr_d    [NUM_DST];
    logic [15:0]       src_dst     [NUM_SRC];

    logic [NUM_SRC-1:0] src_granted;
    logic [NUM_SRC-1:0] src_req;
    logic [NUM_SRC-1:0] drop_head;
    logic [31:0]        drop_count_q;
    logic               rst_done_q;

    always_comb begin
        src_granted = '0;
        for (int j = 0; j < int'(NUM_DST); j++) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (dst_state_q[j] == DstBusy && grant_q[j] == SW'(i)) begin
                    src_granted[i] = 1'b1;
                end
            end
        end
    end

    // Route decode happens only for a free source sitting on a head beat.
    always_comb begin
        src_req     = '0;
        drop_head   = '0;
        src_state_d = src_state_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_dst[i] = s_axis_tuser_dst[16*i +: 16];
            if (src_state_q[i] == SrcHead && !src_granted[i] && s_axis_tvalid[i]) begin
                if (32'(src_dst[i]) < NUM_DST) begin
                    src_req[i] = 1'b1;
                end else begin
                    drop_head[i] = 1'b1;
                    if (!s_axis_tlast[i]) begin
                        src_state_d[i] = SrcDrop;
                    end
                end
            end else if (src_state_q[i] == SrcDrop && s_axis_tvalid[i] && s_axis_tlast[i]) begin
                src_state_d[i] = SrcHead;
            end
        end
    end

    always_comb begin
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        dst_state_d = dst_state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        for (int j = 0; j < int'(NUM_DST); j++) begin
            if (dst_state_q[j] == DstIdle) begin
                found = 1'b0;
                for (int k = 0; k < int'(NUM_SRC); k++) begin
                    idx = int'(rr_ptr_q[j]) + k;
                    if (idx >= int'(NUM_SRC)) begin
                        idx = idx - int'(NUM_SRC);
                    end
                    if (!found && src_req[idx] && src_dst[idx] == 16'(j)) begin
                        found          = 1'b1;
                        grant_d[j]     = SW'(idx);
                        rr_ptr_d[j]    = SW'((idx + 1) % int'(NUM_SRC));
                        dst_state_d[j] = DstBusy;
                    end
                end
            end else if (s_axis_tvalid[grant_q[j]] && s_axis_tlast[grant_q[j]] &&
                         m_axis_tready[j]) begin
                dst_state_d[j] = DstIdle;
            end
        end
    end

    // Busy destinations form a purely combinational path to their granted source.
    always_comb begin
        int unsigned gi;
        gi                = 0;
        s_axis_tready     = '0;
        m_axis_tvalid     = '0;
        m_axis_tlast      = '0;
        m_axis_tdata      = '0;
        m_axis_tkeep      = '0;
        m_axis_tuser_size = '0;
        m_axis_tuser_src  = '0;
        m_axis_tuser_dst  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            s_axis_tready[i] = drop_head[i] || (src_state_q[i] == SrcDrop);
        end
        for (int j = 0; j < int'(NUM_DST); j++) begin
            if (dst_state_q[j] == DstBusy) begin
                gi                                 = 32'(grant_q[j]);
                m_axis_tvalid[j]                   = s_axis_tvalid[gi];
                m_axis_tlast[j]                    = s_axis_tlast[gi];
                m_axis_tdata[j*DATA_W +: DATA_W]   = s_axis_tdata[gi*DATA_W +: DATA_W];
                m_axis_tkeep[j*KEEP_W +: KEEP_W]   = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
                m_axis_tuser_size[j*16 +: 16]      = s_axis_tuser_size[gi*16 +: 16];
                m_axis_tuser_dst[j*16 +: 16]       = s_axis_tuser_dst[gi*16 +: 16];
                m_axis_tuser_src[j*16 +: 16]       = (STAMP_SRC != 0) ? 16'(grant_q[j]) :
                                                     s_axis_tuser_src[gi*16 +: 16];
                s_axis_tready[gi]                  = s_axis_tready[gi] | m_axis_tready[j];
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            src_state_q  <= '{default: SrcHead};
            dst_state_q  <= '{default: DstIdle};
            grant_q      <= '{default: '0};
            rr_ptr_q     <= '{default: '0};
            drop_count_q <= '0;
            rst_done_q   <= 1'b0;
        end else begin
            src_state_q  <= src_state_d;
            dst_state_q  <= dst_state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_count_q <= drop_count_q + 32'($countones(drop_head));
            rst_done_q   <= 1'b1;
        end
    end

    assign drop_count   = drop_count_q;
    assign mod_rst_done = rst_done_q;

endmodule
